// File: rtl/l1_to_l2_request_arbiter_pkg.sv
// Shared types and constants for the L1I/L1D to L2 request arbiter.
package l1_l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE,
        RELEASE
    } arb_state_e;

    localparam logic PORT_L1I = 1'b0;
    localparam logic PORT_L1D = 1'b1;

    localparam int BLOCK_WORDS_DEF = 16;

endpackage

// File: rtl/l1_to_l2_request_arbiter_if.sv
// L1 request ports and L2 block channel seen by the arbiter.
interface l1_to_l2_request_arbiter_if #(
    parameter int BW_ADDR = 24,
    parameter int BW_DATA = 32
);
    logic               req0_i, req1_i;
    logic               rw0_i, rw1_i;
    logic [BW_ADDR-1:0] add0_i, add1_i;
    logic [BW_DATA-1:0] data0_i, data1_i;
    logic [BW_DATA-1:0] data0_o, data1_o;
    logic               valid0_o, valid1_o;
    logic               next0_o, next1_o;
    logic               done0_o, done1_o;
    logic               l2_req_o, l2_rw_o;
    logic [BW_ADDR-1:0] l2_add_o;
    logic [BW_DATA-1:0] l2_data_o, l2_data_i;
    logic               l2_valid_i, l2_ready_write_i, l2_done_i;
    logic               err_o;

    modport master (
        input  req0_i, req1_i, rw0_i, rw1_i, add0_i, add1_i,
        input  data0_i, data1_i, l2_data_i,
        input  l2_valid_i, l2_ready_write_i, l2_done_i,
        output data0_o, data1_o, valid0_o, valid1_o,
        output next0_o, next1_o, done0_o, done1_o,
        output l2_req_o, l2_rw_o, l2_add_o, l2_data_o, err_o
    );

    modport slave (
        output req0_i, req1_i, rw0_i, rw1_i, add0_i, add1_i,
        output data0_i, data1_i, l2_data_i,
        output l2_valid_i, l2_ready_write_i, l2_done_i,
        input  data0_o, data1_o, valid0_o, valid1_o,
        input  next0_o, next1_o, done0_o, done1_o,
        input  l2_req_o, l2_rw_o, l2_add_o, l2_data_o, err_o
    );
endinterface

// File: rtl/l1_to_l2_request_arbiter_rr_picker.sv
// Two-way round-robin picker; the pointer only moves when both ports contend.
module l1_l2_rr_picker
    import l1_l2_arb_pkg::*;
(
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic       gnt_o
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = PORT_L1I;
        ptr_d = ptr_q;
        unique case (req_i)
            2'b11: begin
                gnt_o = ptr_q;
                if (en_i) ptr_d = ~ptr_q;
            end
            2'b10:   gnt_o = PORT_L1D;
            default: gnt_o = PORT_L1I;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) ptr_q <= PORT_L1I;
        else           ptr_q <= ptr_d;
    end
endmodule

// File: rtl/l1_to_l2_request_arbiter.sv
// Shares the L1<->L2 block channel between L1I (port 0) and L1D (port 1).
// Define L1_L2_ARB_PERF_EN to add grant/contention performance counters.
module l1_to_l2_request_arbiter
    import l1_l2_arb_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int BW_ADDR     = 24,
    parameter int BW_DATA     = 32
) (
    input  logic clock_i,
    input  logic resetn_i,
`ifdef L1_L2_ARB_PERF_EN
    input  logic        perf_clear_i,
    output logic [31:0] perf_grant0_o,
    output logic [31:0] perf_grant1_o,
    output logic [31:0] perf_contend_o,
`endif
    l1_to_l2_request_arbiter_if.master bus
);
    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int CW = OW + 1;

    arb_state_e         state_q, state_d;
    logic               gnt_q, gnt_d, rw_q, rw_d;
    logic               err_q, err_d, rvalid_q, rvalid_d;
    logic [BW_ADDR-1:0] add_q, add_d, add_sel;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW_DATA-1:0] rdata_q, rdata_d;
    logic [1:0]         req;
    logic               pick, idle, xfer, full, beat, wr_take;

    assign req     = {bus.req1_i, bus.req0_i};
    assign idle    = (state_q == IDLE);
    assign xfer    = (state_q == XFER);
    assign full    = (cnt_q == CW'(BLOCK_WORDS));
    assign beat    = rw_q ? bus.l2_ready_write_i : bus.l2_valid_i;
    assign wr_take = xfer & rw_q & bus.l2_ready_write_i & ~full;
    assign add_sel = pick ? bus.add1_i : bus.add0_i;

    l1_l2_rr_picker u_picker (
        .clock_i  (clock_i),
        .resetn_i (resetn_i),
        .en_i     (idle),
        .req_i    (req),
        .gnt_o    (pick)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rw_d     = rw_q;
        add_d    = add_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    rw_d    = pick ? bus.rw1_i : bus.rw0_i;
                    add_d   = {add_sel[BW_ADDR-1:OW], {OW{1'b0}}};
                    cnt_d   = '0;
                    rdata_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                // beats past a full block are dropped and flagged
                if (beat) begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (!rw_q) begin
                            rdata_d  = bus.l2_data_i;
                            rvalid_d = 1'b1;
                        end
                    end
                end
                if (bus.l2_done_i) begin
                    state_d = DONE;
                    if (cnt_d != CW'(BLOCK_WORDS)) err_d = 1'b1;
                end
            end
            DONE:    state_d = RELEASE;
            RELEASE: if (!req[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= IDLE;
            gnt_q    <= PORT_L1I;
            rw_q     <= 1'b0;
            add_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rw_q     <= rw_d;
            add_q    <= add_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.data0_o   = (gnt_q == PORT_L1I) ? rdata_q : '0;
    assign bus.data1_o   = (gnt_q == PORT_L1D) ? rdata_q : '0;
    assign bus.valid0_o  = rvalid_q & (gnt_q == PORT_L1I);
    assign bus.valid1_o  = rvalid_q & (gnt_q == PORT_L1D);
    assign bus.next0_o   = wr_take & (gnt_q == PORT_L1I);
    assign bus.next1_o   = wr_take & (gnt_q == PORT_L1D);
    assign bus.done0_o   = (state_q == DONE) & (gnt_q == PORT_L1I);
    assign bus.done1_o   = (state_q == DONE) & (gnt_q == PORT_L1D);
    assign bus.l2_req_o  = xfer;
    assign bus.l2_rw_o   = rw_q;
    assign bus.l2_add_o  = add_q;
    assign bus.l2_data_o = (xfer & rw_q) ? (gnt_q ? bus.data1_i : bus.data0_i) : '0;
    assign bus.err_o     = err_q;

`ifdef L1_L2_ARB_PERF_EN
    logic [31:0] pg0_q, pg1_q, pc_q;
    logic        grant_ev, contend;

    assign grant_ev = idle & (|req);
    assign contend  = idle ? (&req) : req[~gnt_q];

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pc_q  <= '0;
        end else if (perf_clear_i) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pc_q  <= '0;
        end else begin
            if (grant_ev & ~pick & ~&pg0_q) pg0_q <= pg0_q + 1'b1;
            if (grant_ev &  pick & ~&pg1_q) pg1_q <= pg1_q + 1'b1;
            if (contend & ~&pc_q)           pc_q  <= pc_q + 1'b1;
        end
    end

    assign perf_grant0_o  = pg0_q;
    assign perf_grant1_o  = pg1_q;
    assign perf_contend_o = pc_q;
`else
    // counters are absent in this build
`endif
endmodule

// File: doc/l1_to_l2_request_arbiter.md
Name: l1_to_l2_request_arbiter

Overview:
Shares the single L1<->L2 block-transfer channel between the L1 instruction cache (port 0) and the L1 data cache (port 1). It arbitrates miss fills and writebacks, sequences one whole-block transfer at a time, and steers per-word data and strobes between the L2 and the granted L1. It sits between both L1 caches and the L2 cache inside the internal memory controller.

Parameters:
BLOCK_WORDS, 16, words per cache block; power of two, at least 2.
BW_ADDR, 24, word-address width.
BW_DATA, 32, data width.

Ports:
clock_i  in  1  system clock
resetn_i  in  1  asynchronous, active-low reset
req0_i/req1_i  in  1  block request from L1I/L1D; level, held until done
rw0_i/rw1_i  in  1  0=read (fill), 1=write (writeback); stable while req high
add0_i/add1_i  in  BW_ADDR  word address of the block
data0_i/data1_i  in  BW_DATA  current write word from the requester
data0_o/data1_o  out  BW_DATA  read word to the requester
valid0_o/valid1_o  out  1  read-word strobe
next0_o/next1_o  out  1  write word consumed; requester advances to the next word
done0_o/done1_o  out  1  transfer-complete pulse
l2_req_o  out  1  request to L2
l2_rw_o  out  1  latched rw
l2_add_o  out  BW_ADDR  latched, block-aligned address
l2_data_o  out  BW_DATA  write word to L2
l2_data_i  in  BW_DATA  read word from L2
l2_valid_i  in  1  read word valid
l2_ready_write_i  in  1  L2 accepts l2_data_o this cycle
l2_done_i  in  1  L2 transfer complete
err_o  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, any state): state IDLE, round-robin pointer=0 (port 0 favoured), word count=0. All outputs 0, err_o=0.
- IDLE:
  - One requester active: that port is granted.
  - Both active: the port named by the pointer is granted, then the pointer moves to the other port.
  - Single request: the pointer is unchanged.
  - The grant, rw and add are registered. l2_req_o=1 in the cycle after req is first seen (1-cycle latency). Next state XFER.
- l2_add_o = {add[BW_ADDR-1:log2(BLOCK_WORDS)], zeros}.
- XFER: l2_req_o is held high.
  - Read: on each l2_valid_i, the granted data_o is registered from l2_data_i and valid_o pulses the next cycle (1-cycle latency). The count increments.
  - Write: l2_data_o = granted data_i (combinational). next_o = l2_ready_write_i for the granted port only (same cycle). The count increments on each such cycle.
  - The non-granted port's outputs stay 0.
  - Count width is log2(BLOCK_WORDS)+1 and saturates at BLOCK_WORDS. Beats beyond BLOCK_WORDS are dropped (no strobe) and set err_o.
- On l2_done_i:
  - l2_req_o drops the next cycle and state goes to DONE.
  - If count != BLOCK_WORDS, err_o is set.
  - If l2_done_i coincides with the final l2_valid_i, the word is still delivered and counted.
- DONE: the granted done_o pulses for exactly 1 cycle, then state RELEASE.
- RELEASE: wait for the granted req_i to go low, then IDLE. A re-asserted request is re-arbitrated; a held-high request is never double-served.
- A request arriving outside IDLE is held, not lost. Round-robin bounds the wait to one transfer.
- err_o stays set until reset.

Optional Feature:
L1_L2_ARB_PERF_EN
- Defined: adds output ports perf_grant0_o[31:0], perf_grant1_o[31:0] and perf_contend_o[31:0].
  - perf_grant0_o/perf_grant1_o count grants per port.
  - perf_contend_o counts cycles where a non-granted req is high.
  - The counters saturate at all-ones, reset to 0, and are cleared by input perf_clear_i.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package l1_l2_arb_pkg: state encoding (IDLE, XFER, DONE, RELEASE), port-ID constants PORT_L1I=0 and PORT_L1D=1, default BLOCK_WORDS.
- One sub-module, l1_l2_rr_picker: a 2-way round-robin grant plus pointer update, purely registered-pointer logic.

Test Plan:
1. req0 read, add=0x00012B, BLOCK_WORDS=16, 16 l2_valid_i beats -> l2_add_o=0x000120, l2_req_o high from cycle+1; 16 valid0_o pulses with matching data; done0_o for 1 cycle; err_o=0.
2. req0 and req1 rise in the same cycle after reset -> port 0 is served first, then port 1. A second simultaneous pair is served port 1 first.
3. req1 write, l2_ready_write_i every other cycle -> 16 next1_o pulses aligned with ready; l2_data_o tracks data1_i; no next0_o.
4. l2_done_i after 10 read beats -> done pulse, err_o=1 and stays set. 17th beat in a separate run -> dropped, err_o=1.
5. resetn_i low mid-XFER (word 7) -> all outputs 0 immediately; a fresh request afterwards completes normally.
6. req0 held high for 3 cycles after done0_o -> no second grant until it drops; re-asserting it yields a new transfer.
